// File: rtl/alu_share_arbiter_if.sv
// Request, ALU-issue and response bundle between the shared-ALU arbiter and its environment.
// The master side covers the two requesters plus the ALU; the arbiter uses the slave side.
interface alu_share_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic [1:0]              req_valid_i;
   logic [1:0]              req_ready_o;
   logic [1:0]              req_funct7_i;
   logic [5:0]              req_alu_op_i;
   logic [5:0]              req_funct3_i;
   logic [2*DATA_WIDTH-1:0] req_a_i;
   logic [2*DATA_WIDTH-1:0] req_b_i;

   logic                    alu_funct7_o;
   logic [2:0]              alu_op_o;
   logic [2:0]              alu_funct3_o;
   logic [DATA_WIDTH-1:0]   alu_a_o;
   logic [DATA_WIDTH-1:0]   alu_b_o;
   logic [DATA_WIDTH-1:0]   alu_result_i;
   logic                    alu_zero_i;

   logic [1:0]              rsp_valid_o;
   logic [1:0]              rsp_ready_i;
   logic [DATA_WIDTH-1:0]   rsp_data_o;
   logic                    rsp_zero_o;

   logic                    busy_o;
   logic [CNT_WIDTH-1:0]    grant_cnt0_o;
   logic [CNT_WIDTH-1:0]    grant_cnt1_o;

   modport master (
      output req_valid_i, req_funct7_i, req_alu_op_i, req_funct3_i, req_a_i, req_b_i,
      output alu_result_i, alu_zero_i, rsp_ready_i,
      input  req_ready_o, alu_funct7_o, alu_op_o, alu_funct3_o, alu_a_o, alu_b_o,
      input  rsp_valid_o, rsp_data_o, rsp_zero_o, busy_o, grant_cnt0_o, grant_cnt1_o
   );

   modport slave (
      input  req_valid_i, req_funct7_i, req_alu_op_i, req_funct3_i, req_a_i, req_b_i,
      input  alu_result_i, alu_zero_i, rsp_ready_i,
      output req_ready_o, alu_funct7_o, alu_op_o, alu_funct3_o, alu_a_o, alu_b_o,
      output rsp_valid_o, rsp_data_o, rsp_zero_o, busy_o, grant_cnt0_o, grant_cnt1_o
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters; accept -> issue next cycle -> response the cycle after.
// Requests stall (ready low) from accept until the owner takes the response; the response holds until accepted.
module alu_share_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic               clk,
   input  logic               reset,
   alu_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic                  ptr, owner, grant, accept, rsp_done;
   logic                  iss_f7;
   logic [2:0]            iss_op, iss_f3;
   logic [DATA_WIDTH-1:0] iss_a, iss_b;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_zero;
   logic [CNT_WIDTH-1:0]  cnt0, cnt1;

   logic                  sel_f7;
   logic [2:0]            sel_op, sel_f3;
   logic [DATA_WIDTH-1:0] sel_a, sel_b;

   always_comb begin
      state_nxt = state;
      grant     = ptr;
      accept    = 1'b0;
      rsp_done  = 1'b0;
      case (state)
         IDLE: begin
            accept = |bus.req_valid_i;
            case (bus.req_valid_i)
               2'b01:   grant = 1'b0;
               2'b10:   grant = 1'b1;
               default: grant = ptr;
            endcase
            if (accept) state_nxt = EXEC;
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            // Only the owner's ready completes the response.
            rsp_done = bus.rsp_ready_i[owner];
            if (rsp_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sel_f7 = grant ? bus.req_funct7_i[1]                : bus.req_funct7_i[0];
      sel_op = grant ? bus.req_alu_op_i[5:3]              : bus.req_alu_op_i[2:0];
      sel_f3 = grant ? bus.req_funct3_i[5:3]              : bus.req_funct3_i[2:0];
      sel_a  = grant ? bus.req_a_i[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_a_i[DATA_WIDTH-1:0];
      sel_b  = grant ? bus.req_b_i[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_b_i[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr      <= 1'b0;
         owner    <= 1'b0;
         iss_f7   <= 1'b0;
         iss_op   <= '0;
         iss_f3   <= '0;
         iss_a    <= '0;
         iss_b    <= '0;
         rsp_data <= '0;
         rsp_zero <= 1'b0;
         cnt0     <= '0;
         cnt1     <= '0;
      end else begin
         if (accept) begin
            owner  <= grant;
            iss_f7 <= sel_f7;
            iss_op <= sel_op;
            iss_f3 <= sel_f3;
            iss_a  <= sel_a;
            iss_b  <= sel_b;
            if (grant) cnt1 <= cnt1 + 1'b1;
            else       cnt0 <= cnt0 + 1'b1;
         end
         if (state == EXEC) begin
            rsp_data <= bus.alu_result_i;
            rsp_zero <= bus.alu_zero_i;
         end
         if (rsp_done) ptr <= ~owner;
      end
   end

   // Ready is masked during reset so no output reads as an accept while reset is asserted.
   assign bus.req_ready_o  = (accept && reset) ? (grant ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rsp_valid_o  = (state == RESP) ? {owner, ~owner} : 2'b00;
   assign bus.rsp_data_o   = rsp_data;
   assign bus.rsp_zero_o   = rsp_zero;
   assign bus.alu_funct7_o = iss_f7;
   assign bus.alu_op_o     = iss_op;
   assign bus.alu_funct3_o = iss_f3;
   assign bus.alu_a_o      = iss_a;
   assign bus.alu_b_o      = iss_b;
   assign bus.busy_o       = (state != IDLE);
   assign bus.grant_cnt0_o = cnt0;
   assign bus.grant_cnt1_o = cnt1;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios then random traffic, checked against a
// transaction-level model (latency in cycles since accept, round-robin by last served requester).
module tb_alu_share_arbiter;
   localparam int DW = 32;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
   alu_share_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;

   // Stand-in ALU: op 0 add, op 1 sub, otherwise R-type decode on funct3/funct7.
   function automatic logic [DW-1:0] alu_fn(input logic [2:0] op, input logic [2:0] f3,
                                            input logic f7, input logic [DW-1:0] a, input logic [DW-1:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         default: begin
            case (f3)
               3'd0:    return f7 ? a - b : a + b;
               3'd4:    return a ^ b;
               3'd6:    return a | b;
               3'd7:    return a & b;
               default: return a + b;
            endcase
         end
      endcase
   endfunction

   assign bus.alu_result_i = alu_fn(bus.alu_op_o, bus.alu_funct3_o, bus.alu_funct7_o, bus.alu_a_o, bus.alu_b_o);
   assign bus.alu_zero_i   = (bus.alu_result_i == '0);

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Requester stimulus
   logic [1:0]    vld = 2'b00;
   logic          f7 [2];
   logic [2:0]    op [2];
   logic [2:0]    f3 [2];
   logic [DW-1:0] a  [2];
   logic [DW-1:0] b  [2];
   logic [1:0]    rrdy = 2'b00;

   // Reference model
   int            age = -1;   // cycles since the outstanding op was accepted, -1 when none
   bit            ptr_m = 1'b0;
   bit            own_m = 1'b0;
   logic          last_f7 = 1'b0;
   logic [2:0]    last_op = '0, last_f3 = '0;
   logic [DW-1:0] last_a = '0, last_b = '0, rsp_d = '0;
   logic          rsp_z = 1'b0;
   int            cnt_m [2] = '{0, 0};
   logic [1:0]    acc = 2'b00;
   bit            chk_en = 1'b0;

   task automatic new_op(input int k);
      f7[k] = 1'($urandom_range(0, 1));
      op[k] = 3'($urandom_range(0, 2));
      f3[k] = 3'($urandom_range(0, 7));
      a[k]  = $urandom;
      b[k]  = ($urandom_range(0, 3) == 0) ? a[k] : $urandom;
   endtask

   task automatic drive();
      bus.req_valid_i  = vld;
      bus.req_funct7_i = {f7[1], f7[0]};
      bus.req_alu_op_i = {op[1], op[0]};
      bus.req_funct3_i = {f3[1], f3[0]};
      bus.req_a_i      = {a[1], a[0]};
      bus.req_b_i      = {b[1], b[0]};
      bus.rsp_ready_i  = rrdy;
   endtask

   task automatic tick();
      logic [1:0] er;
      int         g;
      drive();
      @(negedge clk);
      er = 2'b00;
      g  = 0;
      if (reset && age < 0 && vld != 2'b00) begin
         g = (vld == 2'b11) ? int'(ptr_m) : (vld[1] ? 1 : 0);
         er[g] = 1'b1;
      end
      if (chk_en) begin
         check_eq("req_ready", bus.req_ready_o, er);
         check_eq("alu_ctl", {bus.alu_funct7_o, bus.alu_op_o, bus.alu_funct3_o}, {last_f7, last_op, last_f3});
         check_eq("alu_a", bus.alu_a_o, last_a);
         check_eq("alu_b", bus.alu_b_o, last_b);
         check_eq("rsp_valid", bus.rsp_valid_o, (age >= 2) ? (own_m ? 2'b10 : 2'b01) : 2'b00);
         check_eq("rsp_data", bus.rsp_data_o, rsp_d);
         check_eq("rsp_zero", bus.rsp_zero_o, rsp_z);
         check_eq("busy", bus.busy_o, (age >= 0));
         check_eq("grant_cnt0", bus.grant_cnt0_o, cnt_m[0] % (1 << CW));
         check_eq("grant_cnt1", bus.grant_cnt1_o, cnt_m[1] % (1 << CW));
      end
      acc = er;
      if (!reset) begin
         age = -1; ptr_m = 1'b0; own_m = 1'b0;
         last_f7 = 1'b0; last_op = '0; last_f3 = '0; last_a = '0; last_b = '0;
         rsp_d = '0; rsp_z = 1'b0; cnt_m[0] = 0; cnt_m[1] = 0;
      end else if (age >= 2) begin
         if (rrdy[own_m]) begin
            age   = -1;
            ptr_m = ~own_m;
         end
      end else if (age == 1) begin
         rsp_d = alu_fn(last_op, last_f3, last_f7, last_a, last_b);
         rsp_z = (rsp_d == '0);
         age   = 2;
      end else if (er != 2'b00) begin
         own_m = g[0];
         last_f7 = f7[g]; last_op = op[g]; last_f3 = f3[g]; last_a = a[g]; last_b = b[g];
         cnt_m[g]++;
         age = 1;
      end
      @(posedge clk);
      #1;
      chk_en = 1'b1;
   endtask

   task automatic drain();
      vld  = 2'b00;
      rrdy = 2'b11;
      repeat (3) tick();
   endtask

   task automatic rand_stim();
      for (int k = 0; k < 2; k++) begin
         if (acc[k] || !vld[k]) begin
            if ($urandom_range(0, 1) == 1) begin
               vld[k] = 1'b1;
               new_op(k);
            end else begin
               vld[k] = 1'b0;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            vld[k] = 1'b0;
         end
      end
      rrdy  = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
   endtask

   initial begin
      int ngr;
      for (int k = 0; k < 2; k++) new_op(k);

      // Reset held two cycles with random inputs
      reset = 1'b0;
      vld   = 2'($urandom_range(0, 3));
      rrdy  = 2'($urandom_range(0, 3));
      tick();
      tick();
      reset = 1'b1;

      // Single ADD from req0
      vld = 2'b01; rrdy = 2'b11;
      f7[0] = 1'b0; op[0] = 3'd0; f3[0] = 3'd0; a[0] = 32'd5; b[0] = 32'd7;
      tick();
      check_eq("t2_accept", acc, 2'b01);
      vld = 2'b00;
      check_eq("t2_alu_a", bus.alu_a_o, 32'd5);
      check_eq("t2_alu_b", bus.alu_b_o, 32'd7);
      tick();
      check_eq("t2_rsp_valid", bus.rsp_valid_o, 2'b01);
      check_eq("t2_rsp_data", bus.rsp_data_o, 32'd12);
      drain();

      // Both valid continuously from reset: alternate grants
      reset = 1'b0; tick(); reset = 1'b1;
      new_op(0); new_op(1);
      vld = 2'b11; rrdy = 2'b11; ngr = 0;
      for (int i = 0; i < 40 && ngr < 4; i++) begin
         tick();
         if (acc != 2'b00) begin
            check_eq("t3_order", acc[1], ngr % 2);
            new_op(acc[1] ? 1 : 0);
            ngr++;
         end
      end
      check_eq("t3_ops", ngr, 4);
      check_eq("t3_cnt0", bus.grant_cnt0_o, 2);
      check_eq("t3_cnt1", bus.grant_cnt1_o, 2);
      drain();

      // req1 SUB 3-3 with response held off
      vld = 2'b10; rrdy = 2'b00;
      f7[1] = 1'b0; op[1] = 3'd1; f3[1] = 3'd0; a[1] = 32'd3; b[1] = 32'd3;
      tick();
      check_eq("t4_accept", acc, 2'b10);
      vld = 2'b00;
      tick();
      new_op(0); vld = 2'b01;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("t4_rsp_valid", bus.rsp_valid_o, 2'b10);
         check_eq("t4_rsp_data", bus.rsp_data_o, 32'd0);
         check_eq("t4_rsp_zero", bus.rsp_zero_o, 1'b1);
         check_eq("t4_ready", bus.req_ready_o, 2'b00);
      end
      rrdy = 2'b01;
      tick();
      check_eq("t4_nonowner", bus.rsp_valid_o, 2'b10);
      rrdy = 2'b10;
      tick();
      rrdy = 2'b11;
      tick();
      check_eq("t4_next", acc, 2'b01);
      drain();

      // Reset during EXEC of a req1 op
      new_op(1); vld = 2'b10; rrdy = 2'b11;
      tick();
      check_eq("t5_accept", acc, 2'b10);
      vld = 2'b00; reset = 1'b0;
      tick();
      reset = 1'b1;
      check_eq("t5_busy", bus.busy_o, 1'b0);
      check_eq("t5_rsp_valid", bus.rsp_valid_o, 2'b00);
      check_eq("t5_cnt", {bus.grant_cnt1_o, bus.grant_cnt0_o}, 0);
      new_op(0); new_op(1); vld = 2'b11;
      tick();
      check_eq("t5_grant", acc, 2'b01);
      drain();

      // 16 ops from req1 wrap the 4-bit counter
      reset = 1'b0; tick(); reset = 1'b1;
      new_op(1); vld = 2'b10; rrdy = 2'b11; ngr = 0;
      for (int i = 0; i < 100 && ngr < 16; i++) begin
         tick();
         if (acc[1]) begin
            new_op(1);
            ngr++;
         end
      end
      check_eq("t6_ops", ngr, 16);
      drain();
      check_eq("t6_cnt1", bus.grant_cnt1_o, 0);
      check_eq("t6_cnt0", bus.grant_cnt0_o, 0);

      // Random traffic with occasional reset
      for (int i = 0; i < 2000; i++) begin
         rand_stim();
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
